// File: rtl/btn_pkg.sv
// Shared constants and state encoding for the button front-end (debouncer and
// gesture classifier).
package btn_pkg;

  localparam int unsigned DEB_CNT_W = 24;

  localparam logic [DEB_CNT_W-1:0] DEF_LONG_CYCLES   = 24'd6_000_000;
  localparam logic [DEB_CNT_W-1:0] DEF_DCLICK_CYCLES = 24'd3_000_000;
  localparam logic [DEB_CNT_W-1:0] DEF_REPEAT_CYCLES = 24'd1_200_000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    HELD   = 3'd4
  } btn_cls_state_t;

endpackage

// File: rtl/btn_press_classifier_if.sv
// Debounced button pulses in, one-cycle gesture events out.
interface btn_press_classifier_if;

  logic btn_down;
  logic btn_up;
  logic single_click;
  logic double_click;
  logic long_press;
  logic repeat_tick;
  logic busy;

  modport master (
    output btn_down, btn_up,
    input  single_click, double_click, long_press, repeat_tick, busy
  );

  modport slave (
    input  btn_down, btn_up,
    output single_click, double_click, long_press, repeat_tick, busy
  );

endinterface

// File: rtl/btn_press_classifier_cycle_timer.sv
// Shared up-counter with synchronous clear and an equality terminal-count flag.
module cycle_timer
  import btn_pkg::*;
#(
  parameter int unsigned CNT_W = DEB_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] count_r;

  // Counter register: clear has priority over count enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == tc_val);

endmodule

// File: rtl/btn_press_classifier.sv
// Click / double-click / long-press / auto-repeat classifier driven by the
// debouncer's press and release pulses; all outputs registered.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter logic [DEB_CNT_W-1:0] LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic [DEB_CNT_W-1:0] DCLICK_CYCLES = DEF_DCLICK_CYCLES,
  parameter logic [DEB_CNT_W-1:0] REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned          CNT_W         = DEB_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  btn_press_classifier_if.slave  bus
);

  localparam logic [CNT_W-1:0] LONG_TC_C   = CNT_W'(LONG_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] DCLICK_TC_C = CNT_W'(DCLICK_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] REPEAT_TC_C = CNT_W'(REPEAT_CYCLES - 24'd1);

  btn_cls_state_t   state_r;
  btn_cls_state_t   next_s;
  logic             down_s;
  logic             up_s;
  logic             clr_s;
  logic             en_s;
  logic             tc_s;
  logic [CNT_W-1:0] tc_val_s;
  logic             single_s;
  logic             double_s;
  logic             long_s;
  logic             repeat_s;
  logic             single_r;
  logic             double_r;
  logic             long_r;
  logic             repeat_r;
  logic             busy_r;

  // Simultaneous press and release cancel each other out.
  assign down_s = bus.btn_down & ~bus.btn_up;
  assign up_s   = bus.btn_up & ~bus.btn_down;

  cycle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .en     (en_s),
    .tc_val (tc_val_s),
    .tc     (tc_s)
  );

  // Terminal count selected by the current state.
  always_comb begin
    tc_val_s = '0;
    case (state_r)
      PRESS1:  tc_val_s = LONG_TC_C;
      WAIT2:   tc_val_s = DCLICK_TC_C;
      HELD:    tc_val_s = REPEAT_TC_C;
      default: tc_val_s = '0;
    endcase
  end

  // Next state, timer control and gesture decode; events beat expiries.
  always_comb begin
    next_s   = state_r;
    clr_s    = 1'b1;
    en_s     = 1'b0;
    single_s = 1'b0;
    double_s = 1'b0;
    long_s   = 1'b0;
    repeat_s = 1'b0;
    case (state_r)
      IDLE: begin
        // The press cycle itself is the first held cycle, so long_press
        // lands exactly LONG_CYCLES after the press is sampled.
        if (down_s) begin
          next_s = PRESS1;
          clr_s  = 1'b0;
          en_s   = 1'b1;
        end else begin
          next_s = IDLE;
        end
      end
      PRESS1: begin
        if (up_s) begin
          next_s = WAIT2;
        end else if (tc_s) begin
          next_s = HELD;
          long_s = 1'b1;
        end else begin
          clr_s = 1'b0;
          en_s  = 1'b1;
        end
      end
      WAIT2: begin
        if (down_s) begin
          next_s = PRESS2;
        end else if (tc_s) begin
          next_s   = IDLE;
          single_s = 1'b1;
        end else begin
          clr_s = 1'b0;
          en_s  = 1'b1;
        end
      end
      PRESS2: begin
        if (up_s) begin
          next_s   = IDLE;
          double_s = 1'b1;
        end else begin
          next_s = PRESS2;
        end
      end
      HELD: begin
        if (up_s) begin
          next_s = IDLE;
        end else if (tc_s) begin
          repeat_s = 1'b1;
        end else begin
          clr_s = 1'b0;
          en_s  = 1'b1;
        end
      end
      default: begin
        next_s = IDLE;
      end
    endcase
  end

  // State and output registers; busy also covers the final gesture pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      single_r <= 1'b0;
      double_r <= 1'b0;
      long_r   <= 1'b0;
      repeat_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= next_s;
      single_r <= single_s;
      double_r <= double_s;
      long_r   <= long_s;
      repeat_r <= repeat_s;
      busy_r   <= (next_s != IDLE) | single_s | double_s;
    end
  end

  assign bus.single_click = single_r;
  assign bus.double_click = double_r;
  assign bus.long_press   = long_r;
  assign bus.repeat_tick  = repeat_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Directed bench for btn_press_classifier with short timing parameters.
module tb_btn_press_classifier;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  btn_press_classifier_if bus ();

  btn_press_classifier #(
    .LONG_CYCLES   (24'd20),
    .DCLICK_CYCLES (24'd10),
    .REPEAT_CYCLES (24'd5),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Gesture vector order: {single, double, long, repeat}.
  function automatic logic [3:0] gest();
    return {bus.single_click, bus.double_click, bus.long_press, bus.repeat_tick};
  endfunction

  task automatic test_reset();
    bus.btn_down = 1'b0;
    bus.btn_up   = 1'b0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (gest() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gest: got %b expected 0000", gest());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({gest(), bus.busy} !== 5'b00000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 00000", {gest(), bus.busy});
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_g;
    logic       exp_b;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      exp_g = (c == 16) ? 4'b1000 : 4'b0000;
      exp_b = (c >= 1 && c <= 16);
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL single_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      checks++;
      if (bus.busy !== exp_b) begin
        errors++;
        $display("FAIL single_busy cycle %0d: got %b expected %b", c, bus.busy, exp_b);
      end
      bus.btn_down = (c == 0);
      bus.btn_up   = (c == 5);
    end
  endtask

  task automatic test_double();
    logic [3:0] exp_g;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      exp_g = (c == 13) ? 4'b0100 : 4'b0000;
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL double_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      bus.btn_down = (c == 0 || c == 9);
      bus.btn_up   = (c == 5 || c == 12);
    end
  endtask

  task automatic test_long_repeat();
    logic [3:0] exp_g;
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      if (c == 20)
        exp_g = 4'b0010;
      else if (c == 25 || c == 30 || c == 35 || c == 40)
        exp_g = 4'b0001;
      else
        exp_g = 4'b0000;
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL long_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      checks++;
      if (bus.busy !== (c >= 1 && c <= 40)) begin
        errors++;
        $display("FAIL long_busy cycle %0d: got %b expected %b", c, bus.busy, (c >= 1 && c <= 40));
      end
      bus.btn_down = (c == 0);
      bus.btn_up   = (c == 40);
    end
  endtask

  task automatic test_release_on_expiry();
    logic [3:0] exp_g;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      exp_g = (c == 30) ? 4'b1000 : 4'b0000;
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL expiry_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      bus.btn_down = (c == 0);
      bus.btn_up   = (c == 19);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_g;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      exp_g = (c == 16) ? 4'b1000 : 4'b0000;
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL simul_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      bus.btn_down = (c == 0 || c == 14);
      bus.btn_up   = (c == 5 || c == 14);
    end
  endtask

  task automatic test_reset_mid_window();
    logic [3:0] exp_g;
    for (int c = 0; c <= 28; c++) begin
      @(negedge clk);
      exp_g = (c == 25) ? 4'b1000 : 4'b0000;
      checks++;
      if (gest() !== exp_g) begin
        errors++;
        $display("FAIL rstmid_gest cycle %0d: got %b expected %b", c, gest(), exp_g);
      end
      if (c >= 9 && c <= 12) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL rstmid_busy cycle %0d: got %b expected 0", c, bus.busy);
        end
      end
      if (c == 8) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gest(), bus.busy} !== 5'b00000) begin
          errors++;
          $display("FAIL rstmid_async_clear: got %b expected 00000", {gest(), bus.busy});
        end
      end
      if (c == 10) rst_n = 1'b1;
      bus.btn_down = (c == 0 || c == 12);
      bus.btn_up   = (c == 5 || c == 14);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_double();
    test_long_repeat();
    test_release_on_expiry();
    test_simultaneous();
    test_reset_mid_window();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
